// File: rtl/segdisp_pkg.sv
// Shared definitions for the multiplexed seven-segment display slave:
// register map, CTRL fields, lane masks and the hex-to-segment table.
package segdisp_pkg;

  localparam logic [3:0] ADDR_DATA_LO = 4'd0;
  localparam logic [3:0] ADDR_DATA_HI = 4'd1;
  localparam logic [3:0] ADDR_CTRL    = 4'd2;
  localparam logic [3:0] ADDR_DP      = 4'd3;
  localparam logic [3:0] ADDR_RAW0    = 4'd4;
  localparam logic [3:0] ADDR_STATUS  = 4'd8;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RAW    = 1;
  localparam int CTRL_BRIGHT = 8;

  localparam logic [31:0] CTRL_RESET = 32'h0000_FF00;
  localparam logic [31:0] CTRL_MASK  = 32'h0000_FF03;

  // Bits of a 32-bit register that belong to digits below DIGITS, where
  // each digit owns WIDTH bits starting at digit BASE.
  function automatic logic [31:0] lane_mask(
    input int digits,
    input int base,
    input int width
  );
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (base + (i / width) < digits) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h00;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/register_with_bytelanes.sv
// 32-bit register with per-byte write enables; bits outside MASK
// are held at zero so unimplemented fields read back as 0.
module register_with_bytelanes #(
  parameter logic [31:0] RESET_VAL = '0,
  parameter logic [31:0] MASK      = '1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] q_o
);

  logic [31:0] val_q;
  logic [31:0] val_d;

  always_comb begin
    val_d = val_q;
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) val_d[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
    val_d = val_d & MASK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) val_q <= RESET_VAL & MASK;
    else       val_q <= val_d;
  end

  assign q_o = val_q;

endmodule

// File: rtl/segdisp_scanner.sv
// Digit scan timing: slot prescaler, digit index, PWM dimming,
// anti-ghost guard window and frame counter.
module segdisp_scanner #(
  parameter int DIGITS  = 8,
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [7:0]  bright_i,
  output logic [3:0]  idx_o,
  output logic        active_o,
  output logic        frame_tick_o,
  output logic [15:0] frame_cnt_o
);

  localparam int PW = $clog2(CLK_DIV + 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    pwm_q, pwm_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          last_slot;
  logic          last_dig;

  assign last_slot = (presc_q == PW'(CLK_DIV - 1));
  assign last_dig  = (idx_q == 4'(DIGITS - 1));

  // Disabled state is the restart point: digit 0, prescaler 0, pwm 0.
  always_comb begin
    presc_d = '0;
    idx_d   = '0;
    pwm_d   = '0;
    tick_d  = 1'b0;
    cnt_d   = cnt_q;
    if (enable_i) begin
      pwm_d   = pwm_q + 8'd1;
      presc_d = last_slot ? '0 : presc_q + 1'b1;
      idx_d   = idx_q;
      if (last_slot) begin
        if (last_dig) begin
          idx_d  = '0;
          tick_d = 1'b1;
          cnt_d  = cnt_q + 16'd1;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      pwm_q   <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pwm_q   <= pwm_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  assign active_o = enable_i
                 && (presc_q >= PW'(GUARD))
                 && ((pwm_q < bright_i) || (bright_i == 8'hFF));

  assign idx_o        = idx_q;
  assign frame_tick_o = tick_q;
  assign frame_cnt_o  = cnt_q;

endmodule

// File: rtl/avalon_segdisp_mux.sv
// Avalon-MM slave driving a time-multiplexed seven-segment display
// with hex/raw modes, decimal points, PWM brightness and status.
module avalon_segdisp_mux
  import segdisp_pkg::*;
#(
  parameter int DIGITS           = 8,
  parameter int CLK_DIV          = 50000,
  parameter int GUARD            = 2,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic [3:0]        slave_byteenable,
  output logic [31:0]       slave_readdata,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] digit_en,
  output logic              frame_tick
);

  logic [31:0] data_lo_q;
  logic [31:0] data_hi_q;
  logic [31:0] ctrl_q;
  logic [31:0] dp_q;
  logic [31:0] raw_q [4];

  logic [3:0]  idx;
  logic        active;
  logic [15:0] frame_cnt;
  logic        enable;

  logic [31:0] rd_d, rdata_q;
  logic [7:0]  seg_d, seg_q;
  logic [DIGITS-1:0] dig_d, dig_q;

  logic [63:0]  data_all;
  logic [127:0] raw_all;
  logic [3:0]   nib;

  register_with_bytelanes #(
    .RESET_VAL ('0),
    .MASK      (lane_mask(DIGITS, 0, 4))
  ) u_data_lo (
    .clk     (clk),
    .reset   (reset),
    .we_i    (slave_write && slave_address == ADDR_DATA_LO),
    .be_i    (slave_byteenable),
    .wdata_i (slave_writedata),
    .q_o     (data_lo_q)
  );

  register_with_bytelanes #(
    .RESET_VAL ('0),
    .MASK      (lane_mask(DIGITS, 8, 4))
  ) u_data_hi (
    .clk     (clk),
    .reset   (reset),
    .we_i    (slave_write && slave_address == ADDR_DATA_HI),
    .be_i    (slave_byteenable),
    .wdata_i (slave_writedata),
    .q_o     (data_hi_q)
  );

  register_with_bytelanes #(
    .RESET_VAL (CTRL_RESET),
    .MASK      (CTRL_MASK)
  ) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .we_i    (slave_write && slave_address == ADDR_CTRL),
    .be_i    (slave_byteenable),
    .wdata_i (slave_writedata),
    .q_o     (ctrl_q)
  );

  register_with_bytelanes #(
    .RESET_VAL ('0),
    .MASK      (lane_mask(DIGITS, 0, 1))
  ) u_dp (
    .clk     (clk),
    .reset   (reset),
    .we_i    (slave_write && slave_address == ADDR_DP),
    .be_i    (slave_byteenable),
    .wdata_i (slave_writedata),
    .q_o     (dp_q)
  );

  for (genvar n = 0; n < 4; n++) begin : g_raw
    register_with_bytelanes #(
      .RESET_VAL ('0),
      .MASK      (lane_mask(DIGITS, 4 * n, 8))
    ) u_raw (
      .clk     (clk),
      .reset   (reset),
      .we_i    (slave_write && slave_address == ADDR_RAW0 + 4'(n)),
      .be_i    (slave_byteenable),
      .wdata_i (slave_writedata),
      .q_o     (raw_q[n])
    );
  end

  assign enable = ctrl_q[CTRL_EN];

  segdisp_scanner #(
    .DIGITS  (DIGITS),
    .CLK_DIV (CLK_DIV),
    .GUARD   (GUARD)
  ) u_scan (
    .clk          (clk),
    .reset        (reset),
    .enable_i     (enable),
    .bright_i     (ctrl_q[CTRL_BRIGHT +: 8]),
    .idx_o        (idx),
    .active_o     (active),
    .frame_tick_o (frame_tick),
    .frame_cnt_o  (frame_cnt)
  );

  // Read mux samples pre-write state, so read+write returns old data.
  always_comb begin
    rd_d = '0;
    case (slave_address)
      ADDR_DATA_LO: rd_d = data_lo_q;
      ADDR_DATA_HI: rd_d = data_hi_q;
      ADDR_CTRL:    rd_d = ctrl_q;
      ADDR_DP:      rd_d = dp_q;
      4'd4, 4'd5,
      4'd6, 4'd7:   rd_d = raw_q[slave_address[1:0]];
      ADDR_STATUS:  rd_d = {frame_cnt, 12'h000, idx};
      default:      rd_d = '0;
    endcase
  end

  assign data_all = {data_hi_q, data_lo_q};
  assign raw_all  = {raw_q[3], raw_q[2], raw_q[1], raw_q[0]};
  assign nib      = data_all[{idx, 2'b00} +: 4];

  // Segments follow the scan even in the guard window; only the
  // digit drivers are blanked there.
  always_comb begin
    seg_d = '0;
    dig_d = '0;
    if (enable) begin
      if (ctrl_q[CTRL_RAW]) seg_d = raw_all[{idx, 3'b000} +: 8];
      else seg_d = {dp_q[{1'b0, idx}], hex7(nib)};
    end
    if (active) dig_d = DIGITS'(1) << idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      seg_q   <= '0;
      dig_q   <= '0;
    end else begin
      if (slave_read) rdata_q <= rd_d;
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign slave_readdata = rdata_q;
  assign seg_out  = seg_q ^ {8{SEG_ACTIVE_LOW}};
  assign digit_en = dig_q ^ {DIGITS{DIGIT_ACTIVE_LOW}};

endmodule

// File: tb/tb_avalon_segdisp_mux.sv
// Directed bench for avalon_segdisp_mux: 4 digits, 4-cycle slots,
// 1-cycle guard, active-low pins.
module tb_avalon_segdisp_mux;

  logic        clk;
  logic        reset;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic [3:0]  slave_byteenable;
  logic [31:0] slave_readdata;
  logic [7:0]  seg_out;
  logic [3:0]  digit_en;
  logic        frame_tick;

  int checks;
  int passed;

  avalon_segdisp_mux #(
    .DIGITS           (4),
    .CLK_DIV          (4),
    .GUARD            (1),
    .SEG_ACTIVE_LOW   (1'b1),
    .DIGIT_ACTIVE_LOW (1'b1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .slave_address    (slave_address),
    .slave_read       (slave_read),
    .slave_write      (slave_write),
    .slave_writedata  (slave_writedata),
    .slave_byteenable (slave_byteenable),
    .slave_readdata   (slave_readdata),
    .seg_out          (seg_out),
    .digit_en         (digit_en),
    .frame_tick       (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus tasks are entered and left 1 time unit after a rising edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] be);
    slave_address    = a;
    slave_writedata  = d;
    slave_byteenable = be;
    slave_write      = 1'b1;
    @(posedge clk); #1;
    slave_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    slave_address = a;
    slave_read    = 1'b1;
    @(posedge clk); #1;
    slave_read = 1'b0;
    d = slave_readdata;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (seg_out !== 8'hFF) $display("FAIL rst_seg: got %h want ff", seg_out);
    else passed++;
    checks++;
    if (digit_en !== 4'hF) $display("FAIL rst_dig: got %h want f", digit_en);
    else passed++;
    checks++;
    if (slave_readdata !== 32'h0)
      $display("FAIL rst_rdata: got %h want 0", slave_readdata);
    else passed++;
    checks++;
    if (frame_tick !== 1'b0) $display("FAIL rst_tick: got %b want 0", frame_tick);
    else passed++;
    reset = 1'b0;
    @(posedge clk); #1;
    bus_read(4'd2, r);
    checks++;
    if (r !== 32'h0000_FF00) $display("FAIL rst_ctrl: got %h want 0000ff00", r);
    else passed++;
    bus_read(4'd9, r);
    checks++;
    if (r !== 32'h0) $display("FAIL unmapped_rd: got %h want 0", r);
    else passed++;
  endtask

  task automatic test_hex_scan;
    logic [7:0]  lut [4];
    logic [3:0]  de;
    logic [31:0] r;
    int n;
    int bad_seg;
    int bad_dig;
    int bad_tick;
    lut[0] = 8'h3F; lut[1] = 8'h06; lut[2] = 8'h5B; lut[3] = 8'h4F;
    bad_seg = 0; bad_dig = 0; bad_tick = 0;
    bus_write(4'd0, 32'h0000_3210, 4'hF);
    bus_write(4'd2, 32'h0000_FF01, 4'hF);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      de = ((c % 4) >= 1) ? ~(4'b0001 << (c / 4)) : 4'hF;
      if (seg_out !== ~lut[c / 4]) bad_seg++;
      if (digit_en !== de) bad_dig++;
      if (frame_tick !== (c == 15)) bad_tick++;
    end
    checks++;
    if (bad_seg != 0) $display("FAIL hex_seg: %0d bad cycles want 0", bad_seg);
    else passed++;
    checks++;
    if (bad_dig != 0) $display("FAIL hex_dig: %0d bad cycles want 0", bad_dig);
    else passed++;
    checks++;
    if (bad_tick != 0) $display("FAIL hex_tick: %0d bad cycles want 0", bad_tick);
    else passed++;
    bus_read(4'd8, r);
    checks++;
    if (r !== 32'h0001_0000) $display("FAIL status1: got %h want 00010000", r);
    else passed++;
    n = 0;
    while (frame_tick !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (frame_tick !== 1'b1 && n < 40);
    checks++;
    if (n != 16) $display("FAIL tick_period: got %0d want 16", n);
    else passed++;
    bus_read(4'd8, r);
    checks++;
    if (r !== 32'h0003_0000) $display("FAIL status3: got %h want 00030000", r);
    else passed++;
  endtask

  task automatic test_bytelane;
    logic [31:0] r;
    bus_write(4'd0, 32'hFFFF_FFFF, 4'b0010);
    bus_read(4'd0, r);
    checks++;
    if (r !== 32'h0000_FF10) $display("FAIL bytelane: got %h want 0000ff10", r);
    else passed++;
    bus_write(4'd0, 32'hFFFF_FFFF, 4'hF);
    bus_read(4'd0, r);
    checks++;
    if (r !== 32'h0000_FFFF) $display("FAIL lo_mask: got %h want 0000ffff", r);
    else passed++;
    bus_write(4'd1, 32'hFFFF_FFFF, 4'hF);
    bus_read(4'd1, r);
    checks++;
    if (r !== 32'h0) $display("FAIL hi_mask: got %h want 0", r);
    else passed++;
    bus_write(4'd0, 32'h0000_1234, 4'hF);
    slave_writedata = 32'h0000_ABCD;
    slave_byteenable = 4'hF;
    slave_write = 1'b1;
    slave_read = 1'b1;
    @(posedge clk); #1;
    slave_write = 1'b0;
    slave_read = 1'b0;
    checks++;
    if (slave_readdata !== 32'h0000_1234)
      $display("FAIL rd_wr_same: got %h want 00001234", slave_readdata);
    else passed++;
    bus_read(4'd0, r);
    checks++;
    if (r !== 32'h0000_ABCD) $display("FAIL rd_after: got %h want 0000abcd", r);
    else passed++;
    bus_write(4'd8, 32'hFFFF_FFFF, 4'hF);
    bus_read(4'd8, r);
    checks++;
    if (r[15:4] !== 12'h0) $display("FAIL status_ro: got %h want 000 in [15:4]", r);
    else passed++;
  endtask

  task automatic test_raw;
    logic [7:0] rb [4];
    int bad;
    rb[0] = 8'h01; rb[1] = 8'hAA; rb[2] = 8'h55; rb[3] = 8'h80;
    bad = 0;
    bus_write(4'd2, 32'h0000_FF00, 4'hF);
    bus_write(4'd4, 32'h8055_AA01, 4'hF);
    bus_write(4'd3, 32'h0000_000F, 4'hF);
    bus_write(4'd2, 32'h0000_FF03, 4'hF);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (seg_out !== ~rb[c / 4]) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL raw_seg: %0d bad cycles want 0", bad);
    else passed++;
  endtask

  task automatic test_bright;
    logic [3:0] de;
    int bad;
    int act;
    bad = 0; act = 0;
    bus_write(4'd2, 32'h0000_4000, 4'hF);
    bus_write(4'd2, 32'h0000_4001, 4'hF);
    for (int c = 0; c < 256; c++) begin
      @(posedge clk); #1;
      de = ((c % 4) >= 1 && c < 64) ? ~(4'b0001 << ((c / 4) % 4)) : 4'hF;
      if (digit_en !== de) bad++;
      if (digit_en !== 4'hF) act++;
    end
    checks++;
    if (bad != 0) $display("FAIL pwm_pattern: %0d bad cycles want 0", bad);
    else passed++;
    checks++;
    if (act != 48) $display("FAIL pwm_active: got %0d want 48", act);
    else passed++;
    bus_write(4'd2, 32'h0000_0000, 4'hF);
    bus_write(4'd2, 32'h0000_0001, 4'hF);
    act = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (digit_en !== 4'hF) act++;
    end
    checks++;
    if (act != 0) $display("FAIL bright0: %0d active cycles want 0", act);
    else passed++;
  endtask

  task automatic test_disable;
    logic [31:0] r;
    logic [31:0] r2;
    bus_write(4'd2, 32'h0000_FF00, 4'hF);
    bus_write(4'd2, 32'h0000_FF01, 4'hF);
    repeat (9) begin
      @(posedge clk); #1;
    end
    bus_write(4'd2, 32'h0000_FF00, 4'hF);
    checks++;
    if (digit_en !== 4'hB) $display("FAIL pre_dis: got %h want b", digit_en);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (digit_en !== 4'hF || seg_out !== 8'hFF)
      $display("FAIL dis_out: got %h/%h want f/ff", digit_en, seg_out);
    else passed++;
    bus_read(4'd8, r);
    checks++;
    if (r[3:0] !== 4'h0) $display("FAIL dis_idx: got %h want 0", r[3:0]);
    else passed++;
    repeat (10) @(posedge clk);
    #1;
    bus_read(4'd8, r2);
    checks++;
    if (r2 !== r) $display("FAIL cnt_frozen: got %h want %h", r2, r);
    else passed++;
    bus_write(4'd2, 32'h0000_FF01, 4'hF);
    bus_read(4'd8, r);
    checks++;
    if (r[3:0] !== 4'h0) $display("FAIL reen_idx: got %h want 0", r[3:0]);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (digit_en !== 4'hE) $display("FAIL reen_dig: got %h want e", digit_en);
    else passed++;
  endtask

  task automatic test_async_reset;
    logic [31:0] r;
    repeat (5) @(posedge clk);
    #1;
    bus_read(4'd0, r);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (seg_out !== 8'hFF || digit_en !== 4'hF || frame_tick !== 1'b0)
      $display("FAIL arst_out: got %h/%h/%b want ff/f/0",
               seg_out, digit_en, frame_tick);
    else passed++;
    checks++;
    if (slave_readdata !== 32'h0)
      $display("FAIL arst_rdata: got %h want 0", slave_readdata);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    bus_read(4'd2, r);
    checks++;
    if (r !== 32'h0000_FF00) $display("FAIL arst_ctrl: got %h want 0000ff00", r);
    else passed++;
    bus_read(4'd8, r);
    checks++;
    if (r !== 32'h0) $display("FAIL arst_status: got %h want 0", r);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset = 1'b1;
    slave_address = '0;
    slave_read = 1'b0;
    slave_write = 1'b0;
    slave_writedata = '0;
    slave_byteenable = '0;
    test_reset();
    test_hex_scan();
    test_bytelane();
    test_raw();
    test_bright();
    test_disable();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/avalon_segdisp_mux.md
Name: avalon_segdisp_mux

Overview:
Parametrised Avalon-MM slave that drives a time-multiplexed, multi-digit seven-segment display. It holds per-digit data in byte-lane-writable registers and supports hex-decode or raw-segment mode, per-digit decimal points, a PWM brightness control and a status readback. It sits between the system interconnect and the board display pins.

Parameters:
DIGITS, 8, number of digits driven (1..16).
CLK_DIV, 50000, clk cycles per digit slot (>= GUARD+2).
GUARD, 2, cycles all digits are forced off at the start of each slot (anti-ghosting).
SEG_ACTIVE_LOW, 1, invert seg_out when 1.
DIGIT_ACTIVE_LOW, 1, invert digit_en when 1.

Ports:
clk  in  1  system clock
reset  in  1  reset
slave_address  in  4  word address
slave_read  in  1  read strobe
slave_write  in  1  write strobe
slave_writedata  in  32  write data
slave_byteenable  in  4  byte lanes
slave_readdata  out  32  read data, readLatency 1
seg_out  out  8  segments a..g = bit0..6, dp = bit7
digit_en  out  DIGITS  one-hot digit select
frame_tick  out  1  1-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (already decided): reset reset, asynchronous, active-high; clock clk. All registers clear to 0 except CTRL = 0x0000_FF00. Outputs reset to the inactive level: slave_readdata=0, frame_tick=0, seg_out all-off, digit_en all-off. The polarity parameters apply.
- Register map (word addresses):
  - 0 DATA_LO: nibble i = digit i, digits 0..7.
  - 1 DATA_HI: digits 8..15.
  - 2 CTRL: bit0 enable, bit1 raw_mode, [15:8] bright.
  - 3 DP: [15:0] dp mask.
  - 4..7 RAW: byte k of addr 4+n = raw segments of digit 4n+k.
  - 8 STATUS (read-only): [3:0] current digit, [31:16] frame count, wrapping.
  - Others: read 0, writes ignored.
- Bits, nibbles and bytes belonging to digits >= DIGITS read 0 and ignore writes.
- Writes: take effect on the clock edge where slave_write=1, per byte lane where slave_byteenable=1. Writes to STATUS are ignored.
- Reads: slave_readdata is registered 1 cycle after slave_read and holds its value otherwise. A read on the cycle after a write returns the new value. If read and write are both asserted, the write happens and the read returns the pre-write value.
- Scanner:
  - When enabled, the prescaler counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and the digit index advances, wrapping DIGITS-1 -> 0.
  - frame_tick pulses in the cycle the index wraps to 0. The frame count increments on the same edge.
  - DIGITS=1: the index stays 0 and frame_tick pulses every CLK_DIV cycles.
- Enable/disable:
  - Clearing enable resets the prescaler and index to 0, freezes the frame count, and drives outputs inactive on the next cycle.
  - Setting enable restarts at digit 0, prescaler 0.
- Digit drive:
  - Active when enabled, prescaler >= GUARD, and (pwm < bright or bright==0xFF).
  - pwm is an 8-bit counter, free-running while enabled.
  - bright=0 keeps all digits dark.
- Segment source:
  - raw_mode=0: hex LUT of the digit nibble, dp from the DP mask. Active-high LUT values: 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F A=0x77 b=0x7C C=0x39 d=0x5E E=0x79 F=0x71.
  - raw_mode=1: raw byte as-is. The DP mask is ignored.
- Output timing: seg_out and digit_en are registered, 1 cycle after the index/prescaler/register state. They are inverted at the output stage per the polarity parameters.
- Data rewritten mid-slot appears on seg_out 1 cycle after the write edge. No tearing protection.

Decomposition:
- Package segdisp_pkg: register address constants, CTRL bit/field positions, and the hex-to-segment LUT as a function.
- Reuse register_with_bytelanes for DATA_LO/HI, CTRL, DP and RAW.
- One sub-module, segdisp_scanner: prescaler, digit index, pwm, guard and frame count. It takes enable/bright and outputs index, active and frame_tick.

Test Plan:
- Reset check (DIGITS=4, CLK_DIV=4, GUARD=1, active-low) -> seg_out=0xFF, digit_en=4'hF, readdata=0; read CTRL -> 0x0000_FF00.
- Write DATA_LO=0x0000_3210, CTRL=0x0000_FF01 -> digits 0..3 show 0x3F, 0x06, 0x5B, 0x4F (inverted on pins). Each digit is active 3 of 4 cycles. frame_tick occurs every 16 cycles and STATUS[31:16] increments.
- Byte-lane write DATA_LO=0xFFFF_FFFF, byteenable 4'b0010, then read -> 0x0000_FF10. Read on the cycle after the write returns the new value.
- raw_mode with RAW addr 4 = 0x8055_AA01, DP=0xF -> seg_out (active-high view) shows 0x01, 0xAA, 0x55, 0x80; DP is ignored.
- bright=0x40 -> within a slot, digit active only where pwm < 0x40. bright=0 -> digit_en stays inactive for a full frame.
- Clear enable mid-slot at digit 2 -> outputs inactive next cycle. Re-enable -> scan starts at digit 0 and STATUS[3:0]=0. Reset mid-frame -> everything returns to reset values asynchronously.
